uart_rx_8n1: RTL and testbench
==============================

UART_RX_8N1 -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_CYCLE, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal range 4 or greater.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-003 SHALL have port rstB, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port rx, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port FfFull, input, 1 bit: downstream FIFO full; when high, a received byte is dropped.
REQ-006 SHALL have port dataEn, output, 1 bit: one-cycle strobe marking a valid received byte.
REQ-007 SHALL have port dataOut, output, 8 bits: received byte, valid while dataEn=1 and held afterwards.

Function
REQ-008 SHALL synchronise rx through a 2-flop synchroniser, reset value 1; all decisions SHALL use the synchronised value.
REQ-009 SHALL receive 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-011 IDLE SHALL go to START on a synchronised 1->0 transition of rx and clear the bit-time counter.
REQ-012 START SHALL sample rx at counter = BAUD_CYCLE/2 (integer division); rx=0 goes to DATA with the counter restarted, rx=1 (glitch) returns to IDLE.
REQ-013 DATA SHALL sample rx every BAUD_CYCLE cycles after the start-bit mid-sample and shift it into bit index 0..7 (LSB first); after bit 7 it SHALL go to STOP.
REQ-014 STOP SHALL sample rx BAUD_CYCLE cycles after the bit-7 sample; rx=1 means valid frame, then return to IDLE.
REQ-015 On a valid frame with FfFull=0, SHALL update dataOut and assert dataEn for exactly one cycle, the cycle after the stop-bit sample.
REQ-016 On a valid frame with FfFull=1, SHALL not assert dataEn and SHALL leave dataOut unchanged (byte dropped).
REQ-017 On stop bit = 0 (framing error), SHALL discard the byte, leave dataEn low and dataOut unchanged, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL go to IDLE only after rx is sampled high, so a break condition produces no further bytes.
REQ-019 Back-to-back frames (next start edge right after the stop mid-sample) SHALL all be received with no lost bytes.
REQ-020 End-to-end latency SHALL be at most 2 synchroniser cycles + BAUD_CYCLE/2 + 9*BAUD_CYCLE + 1 cycles from the start-bit falling edge to dataEn.
REQ-021 The bit counter SHALL be ceil(log2(BAUD_CYCLE+1)) bits wide and SHALL never wrap within a bit period.

Reset
REQ-022 While rstB=0: state=IDLE, counters=0, shift register=0, dataOut=8'h00, dataEn=0, synchroniser flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no dataEn; after release the receiver SHALL need a fresh falling edge.

Structure
REQ-024 The state enumeration SHALL live in a shared package (uart_pkg); BAUD_CYCLE stays a module parameter.
REQ-025 Single flat module with no sub-modules; target size 120-200 lines of RTL.

Verification
REQ-026 BAUD_CYCLE=868, send 0xA5 8N1 -> exactly one dataEn pulse, dataOut=8'hA5, within the REQ-020 bound.
REQ-027 Send 0x00, 0xFF, 0x55 back-to-back -> three dataEn pulses with dataOut 0x00, 0xFF, 0x55 in order.
REQ-028 Drive rx low for 100 cycles then high -> no dataEn, state back in IDLE.
REQ-029 Send 0x3C with stop bit = 0, hold rx low 20 bit-times, then send 0x81 -> no pulse for 0x3C, one pulse with 0x81.
REQ-030 FfFull=1 during 0x12, then FfFull=0 during 0x34 -> no pulse for 0x12, one pulse with dataOut=0x34.
REQ-031 Assert rstB=0 during data bit 3 of 0x77, release, then send 0x99 -> no pulse for 0x77, dataOut=0x00 right after reset, then one pulse with 0x99.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver: the receive state encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling, one-cycle byte strobe.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int BAUD_CYCLE = 868
) (
    input  logic       clk,
    input  logic       rstB,
    input  logic       rx,
    input  logic       FfFull,
    output logic       dataEn,
    output logic [7:0] dataOut
);

    localparam int               CNT_W    = $clog2(BAUD_CYCLE + 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_CYCLE / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_CYCLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    uart_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             dataEn_q;
    logic [7:0]       dataOut_q;

    assign dataEn  = dataEn_q;
    assign dataOut = dataOut_q;

    // rx_prev_q lags rx_sync_q by one cycle so IDLE can spot a 1->0 transition.
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            dataEn_q  <= 1'b0;
            dataOut_q <= '0;
        end else begin
            dataEn_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= START;
                    end
                end
                // Counter restarts at the start-bit midpoint so data bits are sampled mid-bit.
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= '0;
                        if (rx_sync_q) begin
                            state_q <= IDLE;
                            if (!FfFull) begin
                                dataOut_q <= shift_q;
                                dataEn_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                // A held-low line (break) parks here until it returns high.
                WAIT_IDLE: begin
                    cnt_q <= '0;
                    if (rx_sync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: directed 8N1 scenarios plus random frames vs. a byte-queue model.
module tb_uart_rx_8n1;
    import uart_pkg::*;

    localparam int B  = 10;
    localparam int BB = 868;

    logic       clk = 1'b0;
    logic       rstB;
    logic       rx;
    logic       FfFull;
    logic       dataEn;
    logic [7:0] dataOut;
    logic       rx_b;
    logic       ff_b;
    logic       dataEn_b;
    logic [7:0] dataOut_b;

    uart_rx_8n1 #(.BAUD_CYCLE(B)) dut (
        .clk     (clk),
        .rstB    (rstB),
        .rx      (rx),
        .FfFull  (FfFull),
        .dataEn  (dataEn),
        .dataOut (dataOut)
    );

    uart_rx_8n1 #(.BAUD_CYCLE(BB)) dut_big (
        .clk     (clk),
        .rstB    (rstB),
        .rx      (rx_b),
        .FfFull  (ff_b),
        .dataEn  (dataEn_b),
        .dataOut (dataOut_b)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int         big_pulses = 0;
    logic [7:0] big_data   = 8'h00;
    time        big_t      = 0;

    always @(negedge clk) begin
        if (dataEn === 1'b1) obs_q.push_back(dataOut);
        if (dataEn_b === 1'b1) begin
            big_pulses = big_pulses + 1;
            big_data   = dataOut_b;
            big_t      = $time;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        cycles(B);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(B);
        end
        rx = stop;
        cycles(B);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'h0, obs_q[i]}, {24'h0, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        time        t0;
        int         lat;
        int         bound;
        logic [7:0] rb;
        logic       rff;
        logic       rstop;
        logic [7:0] byte_77;

        rx = 1'b1; rx_b = 1'b1; FfFull = 1'b0; ff_b = 1'b0; rstB = 1'b0;
        cycles(3);
        chk("reset_dataEn", {31'h0, dataEn}, 32'h0);
        chk("reset_dataOut", {24'h0, dataOut}, 32'h0);
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));
        rstB = 1'b1;
        cycles(2);

        // 0xA5 at the full-rate divisor, with end-to-end latency bound
        t0 = $time;
        rx_b = 1'b0;
        cycles(BB);
        for (int i = 0; i < 8; i++) begin
            rx_b = (8'hA5 >> i) & 8'h01;
            cycles(BB);
        end
        rx_b = 1'b1;
        cycles(2 * BB);
        chk("a5_pulses", big_pulses, 1);
        chk("a5_data", {24'h0, big_data}, 32'hA5);
        chk("a5_held", {24'h0, dataOut_b}, 32'hA5);
        lat   = int'((big_t - t0 - 14) / 10);
        bound = 2 + BB / 2 + 9 * BB + 1;
        chk("a5_latency_in_bound", {31'h0, (lat <= bound)}, 32'h1);

        // back-to-back frames
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        cycles(3 * B);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        check_stream("b2b");

        // short low pulse / break of 100 cycles
        rx = 1'b0;
        cycles(100);
        rx = 1'b1;
        cycles(3 * B);
        chk("break_state_idle", 32'(dut.state_q), 32'(IDLE));
        check_stream("break");

        // framing error followed by a long break, then a good frame
        send(8'h3C, 1'b0);
        cycles(20 * B);
        chk("ferr_wait_idle", 32'(dut.state_q), 32'(WAIT_IDLE));
        rx = 1'b1;
        cycles(2 * B);
        send(8'h81, 1'b1);
        cycles(3 * B);
        exp_q.push_back(8'h81);
        check_stream("ferr");
        chk("ferr_dataOut", {24'h0, dataOut}, 32'h81);

        // FIFO full drops the byte and leaves dataOut alone
        FfFull = 1'b1;
        send(8'h12, 1'b1);
        cycles(2 * B);
        chk("full_dataOut_held", {24'h0, dataOut}, 32'h81);
        FfFull = 1'b0;
        send(8'h34, 1'b1);
        cycles(3 * B);
        exp_q.push_back(8'h34);
        check_stream("full");

        // reset during data bit 3 of 0x77
        byte_77 = 8'h77;
        rx = 1'b0;
        cycles(B);
        for (int i = 0; i < 3; i++) begin
            rx = byte_77[i];
            cycles(B);
        end
        rx = byte_77[3];
        cycles(B / 2);
        rstB = 1'b0;
        rx   = 1'b1;
        cycles(3);
        chk("midreset_dataEn", {31'h0, dataEn}, 32'h0);
        rstB = 1'b1;
        cycles(2);
        chk("midreset_dataOut", {24'h0, dataOut}, 32'h0);
        cycles(12 * B);
        check_stream("midreset");
        send(8'h99, 1'b1);
        cycles(3 * B);
        exp_q.push_back(8'h99);
        check_stream("after_reset");

        // random frames: byte kept only for a good stop bit with room downstream
        for (int n = 0; n < 16; n++) begin
            rb    = 8'($urandom);
            rff   = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 4) != 0);
            FfFull = rff;
            send(rb, rstop);
            if (!rstop) begin
                rx = 1'b1;
                cycles(2 * B);
            end
            if (rstop && !rff) exp_q.push_back(rb);
        end
        FfFull = 1'b0;
        cycles(3 * B);
        check_stream("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
